// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uartTx among NUM_REQ byte producers.
// Latches the winner's byte, runs the tx_data_request handshake and reports accept/done.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_accept,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       tx_data_request,
  output logic [7:0]                 tx_data,
  input  logic                       tx_active,
  input  logic                       tx_finish
);

  localparam int IDW      = $clog2(NUM_REQ);
  localparam int ACK_W    = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W    = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACTIVE,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_req_q, tx_req_d;
  logic [NUM_REQ-1:0]   accept_q, accept_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       cand;
  logic [7:0]           win_data;

  // Rotating search: the requester just after the last winner has top priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_req_d   = tx_req_q;
    accept_d   = '0;
    done_d     = '0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // tx_active guard keeps us off a frame left running across our own reset.
        if (found && !tx_active) begin
          tx_data_d        = win_data;
          grant_id_d       = winner;
          last_d           = winner;
          accept_d[winner] = 1'b1;
          tx_req_d         = 1'b1;
          ack_cnt_d        = '0;
          state_d          = S_REQ;
        end
      end
      S_REQ: begin
        ack_cnt_d = ack_cnt_q + ACK_W'(1);
        if (tx_finish) begin
          done_d[grant_id_q] = 1'b1;
          tx_req_d           = 1'b0;
          gap_cnt_d          = '0;
          state_d            = S_GAP;
        end else if (tx_active) begin
          tx_req_d = 1'b0;
          state_d  = S_ACTIVE;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          err_d     = 1'b1;
          tx_req_d  = 1'b0;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_ACTIVE: begin
        if (tx_finish) begin
          done_d[grant_id_q] = 1'b1;
          gap_cnt_d          = '0;
          state_d            = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q >= GAP_W'(GAP_LAST)) state_d = S_IDLE;
        else                                gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ack_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_req_q   <= 1'b0;
      accept_q   <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_cnt_q  <= ack_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_req_q   <= tx_req_d;
      accept_q   <= accept_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign req_accept      = accept_q;
  assign req_done        = done_q;
  assign grant_id        = grant_id_q;
  assign busy            = busy_q;
  assign err_timeout     = err_q;
  assign tx_data_request = tx_req_q;
  assign tx_data         = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter and requesters, a transaction-level
// reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 5;
  localparam int ACK = 16;
  localparam int CPB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_accept;
  logic [N-1:0]     req_done;
  logic [1:0]       grant_id;
  logic             busy;
  logic             err_timeout;
  logic             tx_data_request;
  logic [7:0]       tx_data;
  logic             tx_active = 1'b0;
  logic             tx_finish = 1'b0;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_accept(req_accept), .req_done(req_done),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .tx_data_request(tx_data_request), .tx_data(tx_data),
    .tx_active(tx_active), .tx_finish(tx_finish)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is "waiting for ack", "on the line" or "in the gap".
  bit           m_waiting, m_online;
  int           m_age, m_gap_left, m_last;
  logic [N-1:0] e_accept, e_done;
  logic         e_err, e_req, e_busy;
  logic [7:0]   e_data;
  int           e_gid;

  function automatic void model_reset();
    m_waiting = 0; m_online = 0; m_age = 0; m_gap_left = 0; m_last = N - 1;
    e_accept = '0; e_done = '0; e_err = 0; e_req = 0; e_busy = 0; e_data = '0; e_gid = 0;
  endfunction

  function automatic void model_finish();
    e_done = '0;
    e_done[e_gid] = 1'b1;
    m_waiting = 0; m_online = 0; e_req = 0;
    m_gap_left = (GAP > 0) ? GAP : 1;
  endfunction

  function automatic void model_step();
    int w;
    bit idle;
    idle = !m_waiting && !m_online && (m_gap_left == 0);
    e_accept = '0; e_done = '0; e_err = 0;
    if (idle) begin
      if (req_valid != 0 && !tx_active) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
        e_accept[w] = 1'b1;
        e_data = req_data[8*w +: 8];
        e_gid = w; m_last = w;
        m_waiting = 1; m_age = 0; e_req = 1;
      end
    end else if (m_waiting) begin
      m_age++;
      if (tx_finish) model_finish();
      else if (tx_active) begin
        m_waiting = 0; m_online = 1; e_req = 0;
      end else if (m_age == ACK) begin
        e_err = 1; m_waiting = 0; e_req = 0;
        m_gap_left = (GAP > 0) ? GAP : 1;
      end
    end else if (m_online) begin
      if (tx_finish) model_finish();
    end else begin
      m_gap_left--;
    end
    e_busy = m_waiting || m_online || (m_gap_left > 0);
  endfunction

  task automatic compare_all();
    check("req_accept", req_accept, e_accept);
    check("req_done", req_done, e_done);
    check("err_timeout", err_timeout, e_err);
    check("tx_data_request", tx_data_request, e_req);
    check("tx_data", tx_data, e_data);
    check("grant_id", grant_id, e_gid);
    check("busy", busy, e_busy);
  endtask

  // Event log used by the directed scenarios.
  int cyc = 0, fin_cyc = -1, gap_meas = -1, last_acc_cyc = -1;
  int done_cnt = 0, done_last = -1, err_cnt = 0, reqhigh_cnt = 0;
  int acc_log[$];

  task automatic observe();
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (req_accept[i]) begin
        acc_log.push_back(i);
        if (acc_log.size() > 1 && fin_cyc >= 0) gap_meas = cyc - fin_cyc;
        last_acc_cyc = cyc;
      end
      if (req_done[i]) begin
        done_cnt++;
        done_last = i;
      end
    end
    if (err_timeout) err_cnt++;
    if (tx_data_request) reqhigh_cnt++;
  endtask

  // Requesters: drop valid after accept (or keep it in hold mode), then present a fresh byte.
  bit hold_mode = 0;
  int req_rate = 0;

  task automatic drive_requesters();
    for (int i = 0; i < N; i++) begin
      if (req_accept[i]) begin
        if (!hold_mode) req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
      end else if (req_rate > 0 && !req_valid[i] && $urandom_range(99) < req_rate) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  // Behavioural transmitter: latches its byte when it picks up a request, 10 bit-times on the line.
  bit         uart_dead = 0;
  int         max_delay = 3;
  int         u_left = 0, u_delay = 0;
  logic [7:0] u_byte, u_expect, u_last_byte;

  task automatic drive_uart();
    tx_finish = 1'b0;
    if (u_left > 0) begin
      tx_active = 1'b1;
      u_left--;
      if (u_left == 0) begin
        tx_finish = 1'b1;
        fin_cyc = cyc;
        u_last_byte = u_byte;
        check("serial_byte", u_byte, u_expect);
        u_delay = $urandom_range(max_delay);
      end
    end else begin
      tx_active = 1'b0;
      if (!uart_dead && tx_data_request) begin
        if (u_delay > 0) u_delay--;
        else begin
          u_byte = tx_data;
          u_expect = e_data;
          tx_active = 1'b1;
          u_left = 10 * CPB - 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (rst_n) compare_all();
    observe();
    drive_requesters();
    drive_uart();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while ((busy || tx_active || req_valid != 0 || u_left != 0) && k < budget);
    check(name, k < budget, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_accept"}, req_accept, 0);
    check({tag, "_done"}, req_done, 0);
    check({tag, "_err"}, err_timeout, 0);
    check({tag, "_txreq"}, tx_data_request, 0);
    check({tag, "_txdata"}, tx_data, 0);
    check({tag, "_gid"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic reset_block();
    rst_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    model_reset();
    u_delay = 0;

    // Power-on reset
    repeat (3) cycle();
    check_reset_values("por");
    rst_n = 1'b1;

    // Single request from requester 2, byte changed right after accept
    req_valid = 4'b0100;
    req_data[23:16] = 8'hAA;
    done_cnt = 0;
    cycle();
    check("single_accept", req_accept, 4'b0100);
    check("single_txdata", tx_data, 8'hAA);
    check("single_gid", grant_id, 2);
    check("single_busy", busy, 1'b1);
    req_data[23:16] = 8'h55;
    wait_idle("single_drain", 500);
    check("single_serial", u_last_byte, 8'hAA);
    check("single_done_cnt", done_cnt, 1);
    check("single_done_id", done_last, 2);

    // All four together after reset
    reset_block();
    acc_log.delete();
    done_cnt = 0;
    req_valid = 4'b1111;
    req_data = 32'h44332211;
    wait_idle("all4_drain", 2000);
    check("all4_n_grants", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check("all4_order", acc_log[i], i);
    check("all4_done_cnt", done_cnt, 4);

    // Fairness: 0 and 3 hold valid permanently
    acc_log.delete();
    gap_meas = -1;
    hold_mode = 1;
    req_valid = 4'b1001;
    req_data = {8'($urandom), 16'h0000, 8'($urandom)};
    k = 0;
    while (acc_log.size() < 4 && k < 2000) begin
      cycle();
      k++;
    end
    check("rr_grants_in_budget", acc_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check("rr_order", acc_log[i], (i % 2 == 0) ? 0 : 3);
    check("rr_finish_to_accept", gap_meas, 7);
    hold_mode = 0;
    req_valid = '0;
    wait_idle("rr_drain", 500);

    // Ack timeout with a transmitter that never answers
    uart_dead = 1;
    reqhigh_cnt = 0; err_cnt = 0; done_cnt = 0;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h3C;
    wait_idle("to_drain", 200);
    check("to_req_high_cycles", reqhigh_cnt, ACK);
    check("to_err_pulses", err_cnt, 1);
    check("to_no_done", done_cnt, 0);
    check("to_busy_low", busy, 1'b0);
    uart_dead = 0;

    // Reset in the middle of a frame, with another request pending
    req_valid = 4'b0100;
    req_data[23:16] = 8'h96;
    k = 0;
    while (!tx_active && k < 100) begin
      cycle();
      k++;
    end
    check("rst_frame_started", tx_active, 1'b1);
    repeat (15) cycle();
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h5A;
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_reset_values("async_rst");
    acc_log.delete();
    fin_cyc = -1;
    repeat (3) cycle();
    rst_n = 1'b1;
    k = 0;
    while (acc_log.size() == 0 && k < 200) begin
      cycle();
      k++;
    end
    check("rst_pending_granted", acc_log.size(), 1);
    if (acc_log.size() > 0) check("rst_pending_id", acc_log[0], 0);
    check("rst_grant_after_frame", (fin_cyc >= 0) && (last_acc_cyc > fin_cyc), 1'b1);
    wait_idle("rst_drain", 500);

    // Randomised traffic
    req_rate = 8;
    repeat (2500) cycle();
    req_rate = 0;
    wait_idle("rand_drain", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
